// File: rtl/daq_buffer_reader_pkg.sv
// Shared constants and FSM state encoding for the DAQ event-buffer readout engine.
package daq_buffer_reader_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 32;
    localparam int LEN_W_DEF  = 12;

    // Payload length sits in the low bits of the header word.
    localparam int LEN_LSB = 0;

    localparam logic [7:0] TRAILER_MARK = 8'hEE;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HDR_WAIT = 2'd1,
        PAYLOAD  = 2'd2,
        ERR      = 2'd3
    } rd_state_t;

endpackage

// File: rtl/daq_rd_skid_fifo.sv
// Synchronous register FIFO holding {last, data} words between the buffer read pipe and the stream.
module daq_rd_skid_fifo
    import daq_buffer_reader_pkg::*;
#(
    parameter int W     = DATA_W_DEF + 1,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 din,
    input  logic                         pop,
    output logic [W-1:0]                 dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wp;
    logic [PTR_W-1:0] rp;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign dout    = mem[rp];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= din;
                wp      <= (wp == PTR_W'(DEPTH - 1)) ? '0 : wp + PTR_W'(1);
            end
            if (do_pop)
                rp <= (rp == PTR_W'(DEPTH - 1)) ? '0 : rp + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/daq_buffer_reader.sv
// Readout engine pulling length-prefixed events from the DAQ buffer onto a valid/ready stream.
// Define DAQ_BUFFER_READER_TRAILER_EN to append a {EE, 00, evt_count} trailer word to each event.
module daq_buffer_reader
    import daq_buffer_reader_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LAT     = 2,
    parameter int LEN_W      = LEN_W_DEF,
    parameter int SKID_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W-1:0] buf_addr,
    input  logic [DATA_W-1:0] buf_dout,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] rd_ptr,
    output logic [15:0]       evt_count,
    output logic              err,
    output rd_state_t         dbg_state
);

    localparam int CNT_W  = $clog2(SKID_DEPTH + 1);
    localparam int SUM_W  = CNT_W + 1;
    localparam int NEED_W = ADDR_W + 1;

    rd_state_t         state;
    logic [ADDR_W-1:0] avail;
    logic [ADDR_W-1:0] hdr_avail;
    logic [LEN_W-1:0]  remaining;
    logic [RD_LAT-1:0] pipe_v;
    logic [RD_LAT-1:0] pipe_last;
    logic [RD_LAT-1:0] pipe_hdr;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  inflight;
    logic              room;
    logic              issue;
    logic              issue_last;
    logic              ret_v;
    logic              ret_hdr;
    logic [LEN_W-1:0]  ret_len;
    logic              hdr_err;
    logic              push_last;
    logic              pop;
    logic              evt_done;
    logic              fifo_empty;
    logic [DATA_W:0]   fifo_dout;

    assign dbg_state = state;
    assign avail     = wr_ptr - buf_addr;
    assign ret_v     = pipe_v[RD_LAT-1];
    assign ret_hdr   = pipe_hdr[RD_LAT-1];
    assign ret_len   = buf_dout[LEN_LSB +: LEN_W];
    assign hdr_err   = (NEED_W'(ret_len) + NEED_W'(1)) > {1'b0, hdr_avail};
    assign push_last = ret_hdr ? (ret_len == '0) : pipe_last[RD_LAT-1];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + CNT_W'(pipe_v[i]);
    end

    // Reads in flight are counted against FIFO space so a returning word always has a slot.
    assign room       = (SUM_W'(fifo_count) + SUM_W'(inflight)) < SUM_W'(SKID_DEPTH);
    assign issue      = room && (((state == IDLE) && enable && (avail != '0)) || (state == PAYLOAD));
    assign issue_last = (state == PAYLOAD) && (remaining == LEN_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v    <= '0;
            pipe_last <= '0;
            pipe_hdr  <= '0;
        end else begin
            pipe_v[0]    <= issue;
            pipe_last[0] <= issue && issue_last;
            pipe_hdr[0]  <= issue && (state == IDLE);
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v[i]    <= pipe_v[i-1];
                pipe_last[i] <= pipe_last[i-1];
                pipe_hdr[i]  <= pipe_hdr[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            buf_addr  <= '0;
            hdr_avail <= '0;
            remaining <= '0;
            err       <= 1'b0;
        end else begin
            if (issue) buf_addr <= buf_addr + ADDR_W'(1);
            case (state)
                IDLE: begin
                    if (issue) begin
                        hdr_avail <= avail;
                        state     <= HDR_WAIT;
                    end
                end
                HDR_WAIT: begin
                    // Earlier payload words may still be returning; only the header decides.
                    if (ret_v && ret_hdr) begin
                        if (hdr_err) begin
                            err   <= 1'b1;
                            state <= ERR;
                        end else if (ret_len == '0) begin
                            state <= IDLE;
                        end else begin
                            remaining <= ret_len;
                            state     <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (issue) begin
                        remaining <= remaining - LEN_W'(1);
                        if (issue_last) state <= IDLE;
                    end
                end
                ERR:     state <= ERR;
                default: state <= IDLE;
            endcase
        end
    end

    daq_rd_skid_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (SKID_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ret_v),
        .din   ({push_last, buf_dout}),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count)
    );

    assign fifo_empty = (fifo_count == '0);

    // Stream handshake: a word transfers on a cycle with m_valid && m_ready; while m_valid is
    // high and m_ready low, m_data/m_last hold and m_valid stays asserted.
`ifdef DAQ_BUFFER_READER_TRAILER_EN
    logic trl_pend;

    assign m_valid  = trl_pend || !fifo_empty;
    assign m_data   = trl_pend ? DATA_W'({TRAILER_MARK, 8'h00, evt_count}) : fifo_dout[DATA_W-1:0];
    assign m_last   = trl_pend;
    assign pop      = !trl_pend && !fifo_empty && m_ready;
    assign evt_done = trl_pend && m_ready;

    always_ff @(posedge clk) begin
        if (rst)                         trl_pend <= 1'b0;
        else if (pop && fifo_dout[DATA_W]) trl_pend <= 1'b1;
        else if (evt_done)               trl_pend <= 1'b0;
    end
`else
    assign m_valid  = !fifo_empty;
    assign m_data   = fifo_dout[DATA_W-1:0];
    assign m_last   = fifo_dout[DATA_W];
    assign pop      = m_valid && m_ready;
    assign evt_done = pop && m_last;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr    <= '0;
            evt_count <= '0;
        end else begin
            if (pop)      rd_ptr    <= rd_ptr + ADDR_W'(1);
            if (evt_done) evt_count <= evt_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_daq_buffer_reader.sv
// Directed bench for daq_buffer_reader with a 2-cycle BRAM model and a {last, data} scoreboard.
module tb_daq_buffer_reader;
    import daq_buffer_reader_pkg::*;

`ifdef DAQ_BUFFER_READER_TRAILER_EN
    localparam bit TRL = 1'b1;
`else
    localparam bit TRL = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        enable;
    logic [14:0] wr_ptr;
    logic [14:0] buf_addr;
    logic [31:0] buf_dout;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;
    logic [14:0] rd_ptr;
    logic [15:0] evt_count;
    logic        err;
    rd_state_t   dbg_state;

    logic [31:0] mem [0:32767];
    logic [14:0] addr_q;
    logic [32:0] exp_q [$];
    int          checks;
    int          errors;
    int          exp_evt;
    bit          chk_bound;
    bit          stall_q;
    logic [32:0] held;

    daq_buffer_reader u_dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .wr_ptr    (wr_ptr),
        .buf_addr  (buf_addr),
        .buf_dout  (buf_dout),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .rd_ptr    (rd_ptr),
        .evt_count (evt_count),
        .err       (err),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // buffer model: address registered, then data registered
    always @(posedge clk) begin
        addr_q   <= buf_addr;
        buf_dout <= mem[addr_q];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        enable  = 1'b1;
        m_ready = 1'b1;
        wr_ptr  = '0;
        repeat (2) tick();
        rst = 1'b0;
        exp_q.delete();
        exp_evt = 0;
    endtask

    // write one event into the buffer model and queue its expected stream words
    task automatic load_event(input int start, input int len, input logic [31:0] seed);
        logic [14:0] a;
        logic [31:0] w;
        a = 15'(start);
        mem[a] = 32'(len);
        exp_q.push_back({(len == 0) && !TRL, 32'(len)});
        for (int j = 1; j <= len; j++) begin
            a = 15'(start + j);
            w = seed + 32'(j);
            mem[a] = w;
            exp_q.push_back({(j == len) && !TRL, w});
        end
        if (TRL) begin
            exp_q.push_back({1'b1, 8'hEE, 8'h00, exp_evt[15:0]});
            exp_evt++;
        end
    endtask

    task automatic drain(input int max_cyc, input bit toggle);
        logic [3:0] pat;
        bit done;
        pat  = 4'b1001;
        done = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            if (toggle) m_ready = pat[i % 4];
            if (exp_q.size() == 0 && !m_valid) begin
                done = 1'b1;
                break;
            end
        end
        m_ready = 1'b1;
        check("drain_done", 64'(done), 64'd1);
        repeat (3) tick();
        check("no_extra_valid", 64'(m_valid), 64'd0);
    endtask

    // scoreboard / stream monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("hold_valid", 64'(m_valid), 64'd1);
                check("hold_word", 64'({m_last, m_data}), 64'(held));
            end
            if (chk_bound) check("fifo_bound", 64'(u_dut.fifo_count <= 3'd4), 64'd1);
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check("extra_word", 64'(exp_q.size()), 64'd1);
                else check("stream_word", 64'({m_last, m_data}), 64'(exp_q.pop_front()));
            end
            stall_q = m_valid && !m_ready;
            held    = {m_last, m_data};
        end
    end

    initial begin
        int lat;
        checks    = 0;
        errors    = 0;
        chk_bound = 1'b0;
        stall_q   = 1'b0;
        do_reset();

        check("rst_buf_addr", 64'(buf_addr), 64'd0);
        check("rst_rd_ptr", 64'(rd_ptr), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_last", 64'(m_last), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_evt_count", 64'(evt_count), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));

        // event L=2 at address 0: 0x002, 0xA, 0xB
        mem[0] = 32'h2;
        mem[1] = 32'hA;
        mem[2] = 32'hB;
        exp_q.push_back({1'b0, 32'h2});
        exp_q.push_back({1'b0, 32'hA});
        exp_q.push_back({!TRL, 32'hB});
        if (TRL) exp_q.push_back({1'b1, 32'hEE00_0000});
        wr_ptr = 15'd3;
        lat = 0;
        while (!m_valid && lat < 10) begin
            tick();
            lat++;
        end
        check("first_word_latency", 64'(lat), 64'd3);
        drain(100, 1'b0);
        check("t1_rd_ptr", 64'(rd_ptr), 64'd3);
        check("t1_buf_addr", 64'(buf_addr), 64'd3);
        check("t1_evt_count", 64'(evt_count), 64'd1);

        // L=0 header, first held off by enable=0
        do_reset();
        mem[0] = 32'h0;
        exp_q.push_back({!TRL, 32'h0});
        if (TRL) exp_q.push_back({1'b1, 32'hEE00_0000});
        enable = 1'b0;
        wr_ptr = 15'd1;
        repeat (6) tick();
        check("en_low_buf_addr", 64'(buf_addr), 64'd0);
        check("en_low_m_valid", 64'(m_valid), 64'd0);
        enable = 1'b1;
        drain(100, 1'b0);
        check("t2_rd_ptr", 64'(rd_ptr), 64'd1);
        check("t2_evt_count", 64'(evt_count), 64'd1);

        // fill to 32766 with 9 events, then an L=5 event wrapping past 32767
        do_reset();
        for (int k = 0; k < 8; k++) load_event(k * 4095, 4094, 32'hF000_0000 + 32'(k * 4096));
        load_event(32760, 5, 32'h5500_0000);
        wr_ptr = 15'd32766;
        drain(40000, 1'b0);
        check("fill_rd_ptr", 64'(rd_ptr), 64'd32766);
        check("fill_evt_count", 64'(evt_count), 64'd9);
        load_event(32766, 5, 32'hCAFE_0000);
        wr_ptr = 15'd4;
        drain(200, 1'b0);
        check("wrap_rd_ptr", 64'(rd_ptr), 64'd4);
        check("wrap_buf_addr", 64'(buf_addr), 64'd4);
        check("wrap_evt_count", 64'(evt_count), 64'd10);

        // 100-word event with m_ready pattern 1,0,0,1
        do_reset();
        load_event(0, 99, 32'h1000_0000);
        chk_bound = 1'b1;
        wr_ptr = 15'd100;
        drain(2000, 1'b1);
        chk_bound = 1'b0;
        check("stall_rd_ptr", 64'(rd_ptr), 64'd100);
        check("stall_evt_count", 64'(evt_count), 64'd1);

        // length overrun: L=10 with only 4 words available
        do_reset();
        mem[0] = 32'hA;
        exp_q.push_back({1'b0, 32'hA});
        wr_ptr = 15'd4;
        drain(100, 1'b0);
        check("ovr_err", 64'(err), 64'd1);
        check("ovr_state", 64'(dbg_state), 64'(ERR));
        check("ovr_buf_addr", 64'(buf_addr), 64'd1);
        check("ovr_rd_ptr", 64'(rd_ptr), 64'd1);
        check("ovr_evt_count", 64'(evt_count), 64'd0);
        wr_ptr = 15'd20;
        repeat (20) tick();
        check("ovr_frozen_addr", 64'(buf_addr), 64'd1);
        check("ovr_sticky_err", 64'(err), 64'd1);
        check("ovr_no_valid", 64'(m_valid), 64'd0);
        do_reset();
        check("ovr_rst_err", 64'(err), 64'd0);
        check("ovr_rst_addr", 64'(buf_addr), 64'd0);

        // two back-to-back L=1 events
        mem[0] = 32'h1;
        mem[1] = 32'h11;
        mem[2] = 32'h1;
        mem[3] = 32'h22;
        exp_q.push_back({1'b0, 32'h1});
        exp_q.push_back({!TRL, 32'h11});
        if (TRL) exp_q.push_back({1'b1, 32'hEE00_0000});
        exp_q.push_back({1'b0, 32'h1});
        exp_q.push_back({!TRL, 32'h22});
        if (TRL) exp_q.push_back({1'b1, 32'hEE00_0001});
        wr_ptr = 15'd4;
        drain(200, 1'b0);
        check("two_rd_ptr", 64'(rd_ptr), 64'd4);
        check("two_evt_count", 64'(evt_count), 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
